// File: rtl/wb_pkg.sv
// wb_pkg: shared types and helpers for the register-file writeback path
package wb_pkg;
    localparam int XLEN = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    function automatic logic [XLEN-1:0] rd_mask(input logic [REG_AW-1:0] rd);
        return XLEN'(1) << rd;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries, power-of-two depth
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  wb_entry_t              din,
    output wb_entry_t              dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t      mem_q [DEPTH];
    wb_entry_t      mem_d [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign dout  = mem_q[rptr_q];
    assign count = count_q;

    // pointers wrap modulo DEPTH through natural overflow
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        if (do_push) mem_d[wptr_q] = din;
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results and queued load returns onto the
// register-file write port and tracks registers with outstanding loads
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   alu_we,
    input  logic [REG_AW-1:0]      alu_rd,
    input  logic [XLEN-1:0]        alu_wdata,
    output logic                   alu_stall,
    input  logic                   ld_issue,
    input  logic [REG_AW-1:0]      ld_issue_rd,
    input  logic                   ld_valid,
    input  logic [REG_AW-1:0]      ld_rd,
    input  logic [XLEN-1:0]        ld_data,
    output logic                   ld_ready,
    output logic [XLEN-1:0]        busy_mask,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   RegWrite,
    output logic [REG_AW-1:0]      Wreg,
    output logic [XLEN-1:0]        Wdata
);
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] WAIT_MAX = SW'(MAX_WAIT);

    wb_entry_t         head, push_entry;
    logic              full, empty, push, pop, alu_req, force_pop;
    logic [SW-1:0]     starve_q, starve_d;
    logic [XLEN-1:0]   busy_q, busy_d;
    logic              regwrite_q, regwrite_d;
    logic [REG_AW-1:0] wreg_q, wreg_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;

    assign push_entry = {ld_rd, ld_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    // a starved load preempts the ALU; otherwise the ALU has priority
    always_comb begin
        alu_req    = alu_we && alu_rd != '0;
        force_pop  = !empty && starve_q == WAIT_MAX;
        pop        = !RST && !empty && (force_pop || !alu_req);
        ld_ready   = !RST && !full;
        alu_stall  = !RST && force_pop;
        push       = ld_valid && ld_ready && ld_rd != '0;
        starve_d   = (empty || pop) ? '0 : (starve_q == WAIT_MAX ? starve_q : starve_q + 1'b1);
        regwrite_d = pop || alu_req;
        wreg_d     = regwrite_d ? (pop ? head.rd : alu_rd) : wreg_q;
        wdata_d    = regwrite_d ? (pop ? head.data : alu_wdata) : wdata_q;
        busy_d     = (busy_q & ~(pop ? rd_mask(head.rd) : '0))
                   | ((ld_issue && ld_issue_rd != '0) ? rd_mask(ld_issue_rd) : '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_q   <= '0;
            busy_q     <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            starve_q   <= starve_d;
            busy_q     <= busy_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    // re-issuing a register whose load is being written this cycle is legal
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(ld_issue && ld_issue_rd != '0 && busy_q[ld_issue_rd]
                      && !(pop && head.rd == ld_issue_rd)));
            assert (!(ld_valid && ld_rd != '0 && !busy_q[ld_rd]));
            assert (!(ld_valid && !ld_ready));
        end
    end

    assign RegWrite  = regwrite_q;
    assign Wreg      = wreg_q;
    assign Wdata     = wdata_q;
    assign busy_mask = busy_q;
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer side of the 32x32 register file write port (RegWrite/Wreg/Wdata).
- Merges two producers into the single write port:
  - single-cycle ALU results;
  - load results returned from the Avalon load/store unit, which arrive at arbitrary times.
- Buffers load results in a small FIFO.
- Keeps a busy scoreboard of registers with outstanding loads, used by decode for hazard stalls.

Parameters:
- DEPTH, 4, load-result FIFO entries (power of two, >=2)
- MAX_WAIT, 8, consecutive cycles a queued load may be starved by the ALU before the ALU is stalled

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous active-high reset
- alu_we  in  1  ALU result valid this cycle
- alu_rd  in  5  ALU destination register
- alu_wdata  in  32  ALU result
- alu_stall  out  1  ALU result not accepted this cycle; upstream holds alu_we/alu_rd/alu_wdata
- ld_issue  in  1  load issued to memory this cycle
- ld_issue_rd  in  5  destination of the issued load
- ld_valid  in  1  load data returned
- ld_rd  in  5  destination of the returned load
- ld_data  in  32  returned load data
- ld_ready  out  1  FIFO can accept a load result
- busy_mask  out  32  bit i = register xi has an outstanding load
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy
- RegWrite  out  1  register file write enable
- Wreg  out  5  register file write address
- Wdata  out  32  register file write data

Behaviour:
- Reset (RST=1 at an edge):
  - FIFO emptied, starve counter=0, busy_mask=0;
  - RegWrite=0, Wreg=0, Wdata=0;
  - ld_ready=0 and alu_stall=0 while RST is high.
  - Reset mid-operation discards queued loads; no write is emitted afterwards.
- Outputs RegWrite/Wreg/Wdata are registered, so every write appears exactly 1 cycle after its source is selected.
- x0 protection:
  - An ALU write with alu_rd=0 is dropped and does not occupy the port.
  - A load return with ld_rd=0 is accepted (ld_ready honoured) but not enqueued.
  - ld_issue with ld_issue_rd=0 sets no busy bit.
  - RegWrite is never 1 with Wreg=0.
- Enqueue: ld_valid & ld_ready & ld_rd!=0.
  - ld_ready = (fifo_count<DEPTH).
  - ld_ready is based on current occupancy and ignores a same-cycle pop.
- Write-port arbitration each cycle:
  - A: force = (FIFO non-empty & starve counter==MAX_WAIT).
  - B: If force, then alu_stall=1 (combinational), the FIFO head is popped and written, and the ALU request is ignored.
  - C: Else if alu_we & alu_rd!=0, the ALU is written and the FIFO is not popped.
  - D: Else if the FIFO is non-empty, the head is popped and written.
  - E: Else RegWrite=0 next cycle.
- Starve counter:
  - Cleared on pop or when the FIFO is empty.
  - Otherwise incremented, saturating at MAX_WAIT.
- Load latency: with no ALU traffic, ld_valid at cycle N gives RegWrite at N+2.
- Enqueue and pop in the same cycle are both allowed; fifo_count is unchanged.
- busy_mask:
  - Bit set on ld_issue (rd!=0).
  - Bit cleared when that register's load is popped; the clear is visible in the same cycle RegWrite is asserted.
  - Set and clear of the same bit in the same cycle: set wins.
- Protocol violations, checked by assertion and not handled by RTL:
  - ld_issue to a register whose busy bit is already set (decode stalls WAW);
  - ld_valid to a register whose busy bit is clear;
  - ld_valid while ld_ready=0.

Decomposition:
- Package wb_pkg:
  - XLEN=32, REG_AW=5;
  - typedef struct packed wb_entry_t {logic [4:0] rd; logic [31:0] data;}.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t, parameter DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - Pointers wrap modulo DEPTH.
- regfile_writeback holds the arbiter, starve counter, scoreboard and output registers.

Test Plan:
- T1, ALU write: alu_we=1, alu_rd=5, alu_wdata=0xDEADBEEF at cycle N -> cycle N+1 shows RegWrite=1, Wreg=5, Wdata=0xDEADBEEF. Repeat with alu_rd=0 -> RegWrite stays 0.
- T2, single load:
  - ld_issue rd=7 at N -> busy_mask[7]=1 at N+1.
  - ld_valid rd=7, data 0x00001234 at N+3 with the ALU idle -> RegWrite, Wreg=7, Wdata=0x1234 at N+5, and busy_mask[7]=0 at N+5.
- T3, starvation (DEPTH=4, MAX_WAIT=8):
  - ALU writes every cycle; one load enqueued at N.
  - -> alu_stall=1 only in cycle N+9.
  - -> load written at N+10.
  - -> the held ALU result is written at N+11.
- T4, full: ALU busy every cycle, 5 loads offered back-to-back -> fifo_count reaches 4, ld_ready=0, and the 5th is accepted only after the first pop. Drain order is FIFO order.
- T5, simultaneous set/clear: load to rd=3 popped in the same cycle as ld_issue rd=3 -> busy_mask[3] remains 1.
- T6, reset mid-operation: 3 entries queued, busy_mask=0x000000E0, RST=1 for one cycle -> fifo_count=0, busy_mask=0, RegWrite=0 thereafter, ld_ready=1 after RST deasserts.
